// File: rtl/aclk_controller.sv
`default_nettype none
// ============================================================================
// Module      : aclk_controller
// Description : Alarm-clock keypad sequencer with 4-digit key buffer and
//               load pulses. Optional time validation: ACLK_TIME_CHECK_EN.
// Revision    : 1.0
// ============================================================================
module aclk_controller #(
   parameter int TIMEOUT_SEC = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_second,
   input  logic [3:0] key,
   input  logic       alarm_button,
   input  logic       time_button,
   output logic       load_new_a,
   output logic       load_new_c,
   output logic       show_alarm,
   output logic       show_new_time,
   output logic       shift,
   output logic [3:0] new_time_ms_hr,
   output logic [3:0] new_time_ls_hr,
   output logic [3:0] new_time_ms_min,
   output logic [3:0] new_time_ls_min,
   output logic       entry_error
);

   typedef enum logic [2:0] {
      SHOW_TIME        = 3'd0,
      KEY_STORED       = 3'd1,
      KEY_WAITED       = 3'd2,
      KEY_ENTRY        = 3'd3,
      SHOW_ALARM       = 3'd4,
      SET_ALARM_TIME   = 3'd5,
      SET_CURRENT_TIME = 3'd6
   } state_t;

   localparam logic [3:0] c_timeout = 4'(TIMEOUT_SEC);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_count;
   logic [3:0] r_key_hold;
   logic       w_digit;
   logic       w_timeout;
   logic       w_commit;
   logic       w_time_ok;
   logic       w_reject;

   assign w_digit   = (key < 4'd10);
   assign w_timeout = (r_count == c_timeout);
   assign w_commit  = (r_state == KEY_ENTRY) && (alarm_button || time_button);

`ifdef ACLK_TIME_CHECK_EN
   assign w_time_ok = (new_time_ms_hr <= 4'd2) && (new_time_ls_hr <= 4'd9) &&
                      !((new_time_ms_hr == 4'd2) && (new_time_ls_hr > 4'd3)) &&
                      (new_time_ms_min <= 4'd5);
`else
   assign w_time_ok = 1'b1;
`endif

   assign w_reject = w_commit && !w_time_ok;

   always_comb begin
      w_next = r_state;
      case (r_state)
         SHOW_TIME: begin
            if (alarm_button)  w_next = SHOW_ALARM;
            else if (w_digit)  w_next = KEY_STORED;
         end
         KEY_STORED: w_next = KEY_WAITED;
         KEY_WAITED: begin
            if (!w_digit)       w_next = KEY_ENTRY;
            else if (w_timeout) w_next = SHOW_TIME;
         end
         KEY_ENTRY: begin
            if (w_reject)          w_next = SHOW_TIME;
            else if (alarm_button) w_next = SET_ALARM_TIME;
            else if (time_button)  w_next = SET_CURRENT_TIME;
            else if (w_digit)      w_next = KEY_STORED;
            else if (w_timeout)    w_next = SHOW_TIME;
         end
         SHOW_ALARM: begin
            if (!alarm_button) w_next = SHOW_TIME;
         end
         default: w_next = SHOW_TIME;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= SHOW_TIME;
         r_count         <= 4'd0;
         r_key_hold      <= 4'd0;
         load_new_a      <= 1'b0;
         load_new_c      <= 1'b0;
         show_alarm      <= 1'b0;
         show_new_time   <= 1'b0;
         shift           <= 1'b0;
         entry_error     <= 1'b0;
         new_time_ms_hr  <= 4'd0;
         new_time_ls_hr  <= 4'd0;
         new_time_ms_min <= 4'd0;
         new_time_ls_min <= 4'd0;
      end else begin
         r_state       <= w_next;
         load_new_a    <= (w_next == SET_ALARM_TIME);
         load_new_c    <= (w_next == SET_CURRENT_TIME);
         show_alarm    <= (w_next == SHOW_ALARM);
         shift         <= (w_next == KEY_STORED);
         show_new_time <= (w_next == KEY_STORED) || (w_next == KEY_WAITED) ||
                          (w_next == KEY_ENTRY);
         entry_error   <= w_reject;

         if (w_next == KEY_STORED)
            r_key_hold <= key;

         if ((r_state == KEY_WAITED) || (r_state == KEY_ENTRY)) begin
            if (one_second && !w_timeout)
               r_count <= r_count + 4'd1;
         end else begin
            r_count <= 4'd0;
         end

         if (((r_state == SHOW_TIME) && (w_next == KEY_STORED)) || w_reject) begin
            new_time_ms_hr  <= 4'd0;
            new_time_ls_hr  <= 4'd0;
            new_time_ms_min <= 4'd0;
            new_time_ls_min <= 4'd0;
         end else if (r_state == KEY_STORED) begin
            new_time_ms_hr  <= new_time_ls_hr;
            new_time_ls_hr  <= new_time_ms_min;
            new_time_ms_min <= new_time_ls_min;
            new_time_ls_min <= r_key_hold;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aclk_controller.sv
`default_nettype none
// Testbench for aclk_controller: behavioural reference model plus directed scenarios.
module tb_aclk_controller;

   localparam int T = 10;

   logic       clk = 1'b0;
   logic       reset, one_second, alarm_button, time_button;
   logic [3:0] key;
   logic       load_new_a, load_new_c, show_alarm, show_new_time, shift, entry_error;
   logic [3:0] new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min;

   aclk_controller #(.TIMEOUT_SEC(T)) dut (
      .clk(clk), .reset(reset), .one_second(one_second), .key(key),
      .alarm_button(alarm_button), .time_button(time_button),
      .load_new_a(load_new_a), .load_new_c(load_new_c), .show_alarm(show_alarm),
      .show_new_time(show_new_time), .shift(shift),
      .new_time_ms_hr(new_time_ms_hr), .new_time_ls_hr(new_time_ls_hr),
      .new_time_ms_min(new_time_ms_min), .new_time_ls_min(new_time_ls_min),
      .entry_error(entry_error)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_shift = 0, n_la = 0, n_lc = 0, n_err = 0;
   logic [15:0] load_buf;
   logic [15:0] w_buf;
   assign w_buf = {new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: entry session with digit list, release wait and idle seconds
   bit          m_view, m_entry, m_shift, m_wait, m_la, m_lc, m_err;
   int          m_idle;
   logic [3:0]  m_buf [4];
   logic [3:0]  m_pend;

   function automatic bit valid_time(input logic [3:0] h1, input logic [3:0] h0, input logic [3:0] m1);
`ifdef ACLK_TIME_CHECK_EN
      return (h1 <= 2) && (h0 <= 9) && !(h1 == 2 && h0 > 3) && (m1 <= 5);
`else
      return 1'b1;
`endif
   endfunction

   task automatic clear_buf();
      for (int i = 0; i < 4; i++) m_buf[i] = 4'd0;
   endtask

   task automatic model_step(input bit r, input logic [3:0] k, input bit a, input bit t, input bit tick);
      bit o_shift, o_wait, o_entry, o_pulse, o_view, dig, tout;
      if (r) begin
         {m_view, m_entry, m_shift, m_wait, m_la, m_lc, m_err} = '0;
         m_idle = 0; m_pend = 4'd0;
         clear_buf();
         return;
      end
      o_shift = m_shift; o_wait = m_wait; o_entry = m_entry;
      o_pulse = m_la | m_lc; o_view = m_view;
      dig  = (k <= 4'd9);
      tout = (m_idle == T);
      m_la = 0; m_lc = 0; m_err = 0;
      if (o_entry && !o_shift) begin
         if (tick && m_idle < T) m_idle++;
      end else begin
         m_idle = 0;
      end
      if (o_shift) begin
         m_buf[0] = m_buf[1]; m_buf[1] = m_buf[2]; m_buf[2] = m_buf[3]; m_buf[3] = m_pend;
         m_shift = 0; m_wait = 1;
      end else if (o_wait) begin
         if (!dig) m_wait = 0;
         else if (tout) begin m_wait = 0; m_entry = 0; end
      end else if (o_entry) begin
         if (a || t) begin
            m_entry = 0;
            if (valid_time(m_buf[0], m_buf[1], m_buf[2])) begin
               if (a) m_la = 1; else m_lc = 1;
            end else begin
               m_err = 1;
               clear_buf();
            end
         end else if (dig) begin
            m_shift = 1; m_pend = k;
         end else if (tout) begin
            m_entry = 0;
         end
      end else if (o_view) begin
         if (!a) m_view = 0;
      end else if (!o_pulse) begin
         if (a) m_view = 1;
         else if (dig) begin
            clear_buf(); m_entry = 1; m_shift = 1; m_pend = k;
         end
      end
   endtask

   // Compare process: sample inputs at the edge, check outputs 1 time unit later
   logic       s_rst, s_a, s_t, s_tick;
   logic [3:0] s_key;
   initial begin
      forever begin
         @(posedge clk);
         s_rst = reset; s_key = key; s_a = alarm_button; s_t = time_button; s_tick = one_second;
         #1;
         model_step(s_rst, s_key, s_a, s_t, s_tick);
         check("cycle_outputs",
               {load_new_a, load_new_c, show_alarm, show_new_time, shift, entry_error, w_buf},
               {m_la, m_lc, m_view, m_entry, m_shift, m_err, m_buf[0], m_buf[1], m_buf[2], m_buf[3]});
         if (shift === 1'b1) n_shift++;
         if (entry_error === 1'b1) n_err++;
         if (load_new_a === 1'b1) begin n_la++; load_buf = w_buf; end
         if (load_new_c === 1'b1) begin n_lc++; load_buf = w_buf; end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] d);
      @(negedge clk) key = d;
      @(negedge clk);
      @(negedge clk) key = 4'hF;
      @(negedge clk);
   endtask

   task automatic button(input bit a, input bit t);
      @(negedge clk) begin alarm_button = a; time_button = t; end
      @(negedge clk) begin alarm_button = 1'b0; time_button = 1'b0; end
   endtask

   int b_shift, b_la, b_lc, b_err;
   task automatic snap();
      b_shift = n_shift; b_la = n_la; b_lc = n_lc; b_err = n_err; load_buf = 16'h0;
   endtask

   int hold, pct;

   initial begin
      reset = 1'b1; key = 4'hF; one_second = 1'b0; alarm_button = 1'b0; time_button = 1'b0;
      idle(3);
      check("reset_outputs",
            {load_new_a, load_new_c, show_alarm, show_new_time, shift, entry_error, w_buf}, 32'h0);
      reset = 1'b0;
      idle(2);

      // 23:59 committed with TIME
      snap();
      press(4'd2); press(4'd3); press(4'd5); press(4'd9);
      check("2359_show_new_time", show_new_time, 1);
      button(1'b0, 1'b1);
      idle(3);
      check("2359_shifts", n_shift - b_shift, 4);
      check("2359_load_c_pulses", n_lc - b_lc, 1);
      check("2359_load_a_pulses", n_la - b_la, 0);
      check("2359_load_buf", load_buf, 16'h2359);
      check("2359_back_to_time", show_new_time, 0);

      // 07:30 committed with ALARM
      snap();
      press(4'd0); press(4'd7); press(4'd3); press(4'd0);
      button(1'b1, 1'b0);
      idle(3);
      check("0730_load_a_pulses", n_la - b_la, 1);
      check("0730_load_c_pulses", n_lc - b_lc, 0);
      check("0730_load_buf", load_buf, 16'h0730);

      // Held digit stored once
      snap();
      @(negedge clk) key = 4'd4;
      idle(20);
      key = 4'hF;
      idle(3);
      check("hold4_shifts", n_shift - b_shift, 1);
      check("hold4_buffer", w_buf, 16'h0004);
      check("hold4_in_entry", show_new_time, 1);
      button(1'b0, 1'b1);
      idle(2);

      // Keypad-idle timeout
      snap();
      press(4'd1);
      for (int i = 1; i <= T; i++) begin
         if (i == T) check("timeout_before_last_tick", show_new_time, 1);
         @(negedge clk) one_second = 1'b1;
         @(negedge clk) one_second = 1'b0;
         idle(1);
      end
      check("timeout_exit", show_new_time, 0);
      check("timeout_buffer", w_buf, 16'h0001);
      check("timeout_no_load", (n_la - b_la) + (n_lc - b_lc), 0);

      // 25:00: rejected with the time check, loaded without it
      snap();
      press(4'd2); press(4'd5); press(4'd0); press(4'd0);
      button(1'b0, 1'b1);
      idle(3);
`ifdef ACLK_TIME_CHECK_EN
      check("2500_error_pulses", n_err - b_err, 1);
      check("2500_no_load_c", n_lc - b_lc, 0);
      check("2500_buffer_cleared", w_buf, 16'h0000);
`else
      check("2500_error_pulses", n_err - b_err, 0);
      check("2500_load_c_pulses", n_lc - b_lc, 1);
      check("2500_load_buf", load_buf, 16'h2500);
`endif

      // Reset held 2 cycles mid-entry
      press(4'd1); press(4'd2);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      @(negedge clk) reset = 1'b0;
      check("midentry_reset",
            {load_new_a, load_new_c, show_alarm, show_new_time, shift, entry_error, w_buf}, 32'h0);
      idle(2);

      // Randomized traffic, checked every cycle by the model
      hold = 0; pct = 30;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (i % 200 == 0) pct = ($urandom_range(0, 1) == 1) ? 30 : 3;
         if (hold == 0) begin
            if ($urandom_range(0, 99) < pct) key = 4'($urandom_range(0, 9));
            else key = 4'($urandom_range(10, 15));
            hold = $urandom_range(1, 5);
         end
         hold--;
         alarm_button = ($urandom_range(0, 39) == 0);
         time_button  = ($urandom_range(0, 29) == 0);
         one_second   = ($urandom_range(0, 2) == 0);
         reset        = ($urandom_range(0, 599) == 0);
      end
      @(negedge clk) begin
         reset = 1'b0; key = 4'hF; alarm_button = 1'b0; time_button = 1'b0; one_second = 1'b0;
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
